// File: rtl/router_reg13_if.sv
// Bus between the router control FSM / source side and the router register stage.
// The FSM-side driver uses master; the register stage uses slave.
interface router_reg13_if #(
    parameter int DW = 8
);
    logic          pkt_valid;
    logic [DW-1:0] data_in;
    logic          fifo_full;
    logic          detect_add;
    logic          ld_state;
    logic          laf_state;
    logic          full_state;
    logic          lfd_state;
    logic          rst_int_reg;
    logic [DW-1:0] dout;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          err;

    // No valid/ready pair here: the FSM strobes are one-hot per cycle and every
    // output is a registered level that the FSM samples on the next clock.
    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
               full_state, lfd_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
               full_state, lfd_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_reg13.sv
// Datapath register stage of the 1x3 router: header/full-byte holding, FIFO write
// byte, running parity, and the parity_done / low_pkt_valid / err status flags.
module router_reg13 #(
    parameter int DW = 8
) (
    input logic            clk,
    input logic            resetn,
    router_reg13_if.slave  bus
);
    logic [DW-1:0] header_q,     header_d;
    logic [DW-1:0] full_byte_q,  full_byte_d;
    logic [DW-1:0] dout_q,       dout_d;
    logic [DW-1:0] int_parity_q, int_parity_d;
    logic [DW-1:0] pkt_parity_q, pkt_parity_d;
    logic          parity_done_q, parity_done_d;
    logic          pd_prev_q,     pd_prev_d;
    logic          low_pv_q,      low_pv_d;
    logic          err_q,         err_d;
    logic          cap_ld, cap_laf;

    always_comb begin
        header_d      = header_q;
        full_byte_d   = full_byte_q;
        dout_d        = dout_q;
        int_parity_d  = int_parity_q;
        pkt_parity_d  = pkt_parity_q;
        parity_done_d = parity_done_q;
        pd_prev_d     = parity_done_q;
        low_pv_d      = low_pv_q;
        err_d         = err_q;

        // Parity byte is either taken straight off the bus or replayed from full_byte.
        cap_ld  = bus.ld_state && !bus.pkt_valid && !bus.fifo_full;
        cap_laf = bus.laf_state && low_pv_q && !parity_done_q;

        if (bus.detect_add && bus.pkt_valid)
            header_d = bus.data_in;

        if (bus.lfd_state)
            dout_d = header_q;
        else if (bus.ld_state && !bus.fifo_full)
            dout_d = bus.data_in;
        else if (bus.laf_state)
            dout_d = full_byte_q;

        if (bus.ld_state && bus.fifo_full)
            full_byte_d = bus.data_in;

        if (bus.detect_add)
            int_parity_d = '0;
        else if (bus.lfd_state)
            int_parity_d = int_parity_q ^ header_q;
        else if (bus.pkt_valid && bus.ld_state && !bus.full_state)
            int_parity_d = int_parity_q ^ bus.data_in;

        if (cap_ld)
            pkt_parity_d = bus.data_in;
        else if (cap_laf)
            pkt_parity_d = full_byte_q;

        if (bus.detect_add)
            parity_done_d = 1'b0;
        else if (cap_ld || cap_laf)
            parity_done_d = 1'b1;

        if (bus.rst_int_reg)
            low_pv_d = 1'b0;
        else if (bus.ld_state && !bus.pkt_valid)
            low_pv_d = 1'b1;

        // Compare one clock after parity_done rises, once both parities are registered.
        if (bus.detect_add)
            err_d = 1'b0;
        else if (parity_done_q && !pd_prev_q)
            err_d = (int_parity_q != pkt_parity_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            header_q      <= '0;
            full_byte_q   <= '0;
            dout_q        <= '0;
            int_parity_q  <= '0;
            pkt_parity_q  <= '0;
            parity_done_q <= 1'b0;
            pd_prev_q     <= 1'b0;
            low_pv_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            header_q      <= header_d;
            full_byte_q   <= full_byte_d;
            dout_q        <= dout_d;
            int_parity_q  <= int_parity_d;
            pkt_parity_q  <= pkt_parity_d;
            parity_done_q <= parity_done_d;
            pd_prev_q     <= pd_prev_d;
            low_pv_q      <= low_pv_d;
            err_q         <= err_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pv_q;
    assign bus.err           = err_q;
endmodule

// File: doc/router_reg13.md
Name: router_reg13

Overview:
- Datapath register stage of the 1x3 router. Sits directly downstream of the router control FSM (fsm13) and upstream of the three output FIFOs.
- Consumes the FSM state strobes and produces the byte written into the selected FIFO.
- Holds the header and any byte that arrives while the FIFO is full, and accumulates running parity.
- Generates low_pkt_valid and parity_done back to the FSM, and flags a parity mismatch on err.

Parameters:
- DW, 8, data byte width; all data registers and parity are DW bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous active-low reset
- pkt_valid  input  1  source asserts while header and payload bytes are on data_in; deasserted on the parity byte
- data_in  input  DW  packet byte from source; header bits [1:0] are the destination address
- fifo_full  input  1  full flag of the currently addressed FIFO
- detect_add  input  1  FSM in DECODE_ADDRESS
- ld_state  input  1  FSM in LOAD_DATA
- laf_state  input  1  FSM in LOAD_AFTER_FULL
- full_state  input  1  FSM in FIFO_FULL_STATE
- lfd_state  input  1  FSM in LOAD_FIRST_DATA
- rst_int_reg  input  1  FSM pulse clearing low_pkt_valid (CHECK_PARITY_ERROR)
- dout  output  DW  byte presented to FIFO write port
- parity_done  output  1  packet parity byte captured
- low_pkt_valid  output  1  pkt_valid fell while loading
- err  output  1  parity mismatch for the current packet

Behaviour:
- Reset (resetn=0, async): dout, parity_done, low_pkt_valid, err, header_byte, full_byte, int_parity and pkt_parity all go to 0 immediately. They stay 0 until the first rising edge after release.
- State strobes are mutually exclusive (one-hot from the FSM). The block does not arbitrate.
- Header capture: detect_add && pkt_valid -> header_byte <= data_in.
- dout update rules, in priority order:
  - lfd_state: dout <= header_byte.
  - ld_state && !fifo_full: dout <= data_in.
  - laf_state: dout <= full_byte.
  - Otherwise dout holds.
- Full hold: ld_state && fifo_full -> full_byte <= data_in, and dout holds.
- Latency: data_in to dout is one clock. header_byte to dout is one clock after lfd_state is sampled.
- Internal parity (int_parity):
  - Cleared to 0 on detect_add.
  - lfd_state -> int_parity ^= header_byte.
  - pkt_valid && ld_state && !full_state -> int_parity ^= data_in.
  - The parity byte (pkt_valid=0) is never XORed in.
- Packet parity capture, either condition:
  - ld_state && !pkt_valid && !fifo_full -> pkt_parity <= data_in.
  - laf_state && low_pkt_valid && !parity_done -> pkt_parity <= full_byte.
- parity_done:
  - Set to 1 on either packet parity capture condition.
  - Cleared on detect_add.
  - Otherwise holds.
  - Set and clear in the same cycle is impossible (one-hot strobes).
- low_pkt_valid:
  - Set when ld_state && !pkt_valid.
  - Cleared when rst_int_reg=1; clear wins if both occur in the same cycle.
  - Otherwise holds.
- err:
  - One clock after parity_done rises (registered edge detect), err <= (int_parity != pkt_parity).
  - Cleared on detect_add.
  - Otherwise holds, so err stays valid through CHECK_PARITY_ERROR.
- Boundary cases:
  - fifo_full on the parity byte: the byte goes to full_byte and is captured as parity from LAF.
  - A zero-length packet (header then parity) is legal: int_parity = header only.
  - fifo_full during lfd_state is ignored; the FSM guarantees the target was empty.
  - Reset mid-packet discards all state; the next packet starts clean at detect_add.

Test Plan:
- Reset: resetn=0 for 50 ns mid-activity -> all outputs 0 immediately and after release.
- Good packet, no full:
  - Stimulus: header 8'h05 (addr 01, len 1), payload 8'hA3, parity 8'hA6, with strobe sequence detect_add, lfd, ld, ld.
  - Required: dout sequence 05, A3, A6; low_pkt_valid=1 after the parity cycle; parity_done=1; err=0 one cycle later.
- Bad parity: same packet with parity byte 8'h00 -> parity_done=1, then err=1 next clock. A following detect_add clears err and parity_done.
- Full during payload:
  - Stimulus: header 8'h06, payload 11, 22; fifo_full=1 while 22 is on data_in during ld_state, then full_state, then laf_state.
  - Required: dout holds 11 during full; dout=22 in laf; int_parity = 06^11^22 = 35.
- Full on parity byte: parity 8'h35 arrives with fifo_full=1 and pkt_valid=0 -> low_pkt_valid=1; in laf, pkt_parity=35, parity_done=1, err=0.
- rst_int_reg pulse with low_pkt_valid=1 -> low_pkt_valid=0 next clock; dout and err unchanged.
